// File: rtl/rgb_pixel_unpack.sv
// Byte-stream to RGB pixel unpacker: pops three interleaved colour bytes and pushes one pixel.
// Optional per-row alignment padding removal is compiled in with RGB_PIXEL_UNPACK_ROW_PAD_EN.
module rgb_pixel_unpack #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BGR_ORDER  = 1,
  parameter int unsigned IMG_WIDTH  = 720
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  input_empty,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  output_full,
  output logic                  read_fifo,
  output logic                  write_fifo,
  output logic [DATA_WIDTH-1:0] red,
  output logic [DATA_WIDTH-1:0] green,
  output logic [DATA_WIDTH-1:0] blue
);

  if (IMG_WIDTH == 0) begin : g_img_width_check
    $error("IMG_WIDTH must be nonzero");
  end

`ifdef RGB_PIXEL_UNPACK_ROW_PAD_EN
  typedef enum logic [1:0] {StCollect, StWrite, StPad} state_e;

  localparam int unsigned PadBytes = (4 - ((3 * IMG_WIDTH) % 4)) % 4;
  localparam int unsigned ColW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  // Modulo keeps the constant well-defined when no padding exists.
  localparam logic [1:0] PadLast = 2'((PadBytes + 3) % 4);

  logic [ColW-1:0] col_q, col_d;
  logic [1:0]      pad_q, pad_d;
`else
  typedef enum logic [0:0] {StCollect, StWrite} state_e;
`endif

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] red_q, red_d;
  logic [DATA_WIDTH-1:0] green_q, green_d;
  logic [DATA_WIDTH-1:0] blue_q, blue_d;

  // Strobes are gated by reset so they read 0 immediately while rst is low.
  always_comb begin
    read_fifo  = 1'b0;
    write_fifo = 1'b0;
    unique case (state_q)
      StCollect: read_fifo  = rst & ~input_empty;
      StWrite:   write_fifo = rst & ~output_full;
`ifdef RGB_PIXEL_UNPACK_ROW_PAD_EN
      StPad:     read_fifo  = rst & ~input_empty;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
`ifdef RGB_PIXEL_UNPACK_ROW_PAD_EN
    col_d   = col_q;
    pad_d   = pad_q;
`endif
    unique case (state_q)
      StCollect: begin
        if (!input_empty) begin
          unique case (idx_q)
            2'd0: begin
              if (BGR_ORDER != 0) blue_d = din;
              else                red_d  = din;
            end
            2'd1: green_d = din;
            default: begin
              if (BGR_ORDER != 0) red_d  = din;
              else                blue_d = din;
            end
          endcase
          if (idx_q == 2'd2) begin
            idx_d   = 2'd0;
            state_d = StWrite;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      StWrite: begin
        if (!output_full) begin
`ifdef RGB_PIXEL_UNPACK_ROW_PAD_EN
          if (col_q == ColLast) begin
            col_d = '0;
            if (PadBytes != 0) begin
              pad_d   = 2'd0;
              state_d = StPad;
            end else begin
              state_d = StCollect;
            end
          end else begin
            col_d   = col_q + 1'b1;
            state_d = StCollect;
          end
`else
          state_d = StCollect;
`endif
        end
      end
`ifdef RGB_PIXEL_UNPACK_ROW_PAD_EN
      StPad: begin
        if (!input_empty) begin
          if (pad_q == PadLast) begin
            pad_d   = 2'd0;
            state_d = StCollect;
          end else begin
            pad_d = pad_q + 2'd1;
          end
        end
      end
`endif
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StCollect;
      idx_q   <= 2'd0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
`ifdef RGB_PIXEL_UNPACK_ROW_PAD_EN
      col_q   <= '0;
      pad_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
`ifdef RGB_PIXEL_UNPACK_ROW_PAD_EN
      col_q   <= col_d;
      pad_q   <= pad_d;
`endif
    end
  end

  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;

endmodule

// File: tb/tb_rgb_pixel_unpack.sv
// Scoreboard bench for rgb_pixel_unpack: a byte-FIFO model feeds two DUTs (BGR and RGB order),
// expected pixels are queued at stimulus time and compared on every write strobe.
module tb_rgb_pixel_unpack;

  logic       clk = 1'b0;
  logic       rst;
  logic       input_empty;
  logic [7:0] din;
  logic       output_full;

  logic       rd_b, wr_b, rd_r, wr_r;
  logic [7:0] red_b, green_b, blue_b, red_r, green_r, blue_r;

  always #5 clk = ~clk;

  rgb_pixel_unpack #(.DATA_WIDTH(8), .BGR_ORDER(1), .IMG_WIDTH(720)) u_bgr (
    .clk(clk), .rst(rst), .input_empty(input_empty), .din(din), .output_full(output_full),
    .read_fifo(rd_b), .write_fifo(wr_b), .red(red_b), .green(green_b), .blue(blue_b)
  );

  rgb_pixel_unpack #(.DATA_WIDTH(8), .BGR_ORDER(0), .IMG_WIDTH(720)) u_rgb (
    .clk(clk), .rst(rst), .input_empty(input_empty), .din(din), .output_full(output_full),
    .read_fifo(rd_r), .write_fifo(wr_r), .red(red_r), .green(green_r), .blue(blue_r)
  );

`ifdef RGB_PIXEL_UNPACK_ROW_PAD_EN
  logic       p_empty, p_full, p_rd, p_wr;
  logic [7:0] p_din, p_red, p_green, p_blue;
  logic [7:0] p_src[$];
  logic [23:0] p_exp[$];

  rgb_pixel_unpack #(.DATA_WIDTH(8), .BGR_ORDER(1), .IMG_WIDTH(2)) u_pad (
    .clk(clk), .rst(rst), .input_empty(p_empty), .din(p_din), .output_full(p_full),
    .read_fifo(p_rd), .write_fifo(p_wr), .red(p_red), .green(p_green), .blue(p_blue)
  );
`endif

  // Byte FIFO model: each byte is preceded by gap_q[i] empty cycles.
  logic [7:0]  data_q[$];
  int          gap_q[$];
  // Expected pixels, packed as {byte0, byte1, byte2} in stream order.
  logic [23:0] exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pops = 0;
  int byte_phase = 0;
  int first_pop_cyc = 0;
  int last_wr_cyc = -1;
  int last_stall_cyc = -1;
  int full_hold = 0;
  int stall_cnt = 0;
  bit chk_lat = 0, chk_tput = 0, chk_bp = 0, release_rst = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input int gap);
    data_q.push_back(b);
    gap_q.push_back(gap);
  endtask

  task automatic push_pixel(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    push_byte(b0, 0);
    push_byte(b1, 0);
    push_byte(b2, 0);
    exp_q.push_back({b0, b1, b2});
  endtask

  task automatic tick();
    logic [23:0] e;
    @(negedge clk);
    if (release_rst) begin
      rst = 1'b1;
      release_rst = 0;
    end
    if (data_q.size() > 0 && gap_q[0] > 0) begin
      input_empty = 1'b1;
      din = 8'hE5;
      gap_q[0] = gap_q[0] - 1;
    end else if (data_q.size() > 0) begin
      input_empty = 1'b0;
      din = data_q[0];
    end else begin
      input_empty = 1'b1;
      din = 8'h5A;
    end
    output_full = (full_hold > 0);
`ifdef RGB_PIXEL_UNPACK_ROW_PAD_EN
    p_full = 1'b0;
    p_empty = (p_src.size() == 0);
    p_din = p_empty ? 8'h00 : p_src[0];
`endif
    #1;
    cyc++;
    check("rd_wr_exclusive", {31'd0, rd_b & wr_b}, 32'd0);
    if (rd_b) begin
      check("pop_when_nonempty", {31'd0, input_empty}, 32'd0);
      if (data_q.size() > 0) begin
        void'(data_q.pop_front());
        void'(gap_q.pop_front());
      end
      if (byte_phase == 0) first_pop_cyc = cyc;
      byte_phase = (byte_phase + 1) % 3;
      pops++;
    end
    if (wr_b) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("bgr_blue", {24'd0, blue_b}, {24'd0, e[23:16]});
        check("bgr_green", {24'd0, green_b}, {24'd0, e[15:8]});
        check("bgr_red", {24'd0, red_b}, {24'd0, e[7:0]});
        check("rgb_write", {31'd0, wr_r}, 32'd1);
        check("rgb_red", {24'd0, red_r}, {24'd0, e[23:16]});
        check("rgb_blue", {24'd0, blue_r}, {24'd0, e[7:0]});
        if (chk_lat) check("pop_to_write_latency", cyc - first_pop_cyc, 32'd3);
        if (chk_tput && last_wr_cyc >= 0) check("write_spacing", cyc - last_wr_cyc, 32'd4);
        if (chk_bp) begin
          check("write_after_stall", cyc - last_stall_cyc, 32'd1);
          chk_bp = 0;
        end
      end
      last_wr_cyc = cyc;
    end else if (full_hold > 0 && !rd_b && !input_empty && exp_q.size() > 0) begin
      // Data available yet nothing popped: the block is stalled in its write state.
      check("stall_hold_blue", {24'd0, blue_b}, {24'd0, exp_q[0][23:16]});
      check("stall_hold_red", {24'd0, red_b}, {24'd0, exp_q[0][7:0]});
      check("stall_no_write_rgb", {31'd0, wr_r}, 32'd0);
      stall_cnt++;
      full_hold--;
      last_stall_cyc = cyc;
    end
`ifdef RGB_PIXEL_UNPACK_ROW_PAD_EN
    if (p_rd) begin
      check("pad_pop_when_nonempty", {31'd0, p_empty}, 32'd0);
      if (p_src.size() > 0) void'(p_src.pop_front());
    end
    if (p_wr) begin
      if (p_exp.size() == 0) begin
        check("pad_spurious_write", 32'd1, 32'd0);
      end else begin
        e = p_exp.pop_front();
        check("pad_pixel", {8'd0, p_blue, p_green, p_red}, {8'd0, e});
      end
    end
`endif
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    bit busy = 1;
    while (busy && n < max_cyc) begin
      tick();
      n++;
      busy = (data_q.size() > 0) || (exp_q.size() > 0);
`ifdef RGB_PIXEL_UNPACK_ROW_PAD_EN
      busy = busy || (p_src.size() > 0) || (p_exp.size() > 0);
`endif
    end
    check("pixels_outstanding", exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (4) tick();
  endtask

  initial begin
    int pops_before;
    rst = 1'b1;
    input_empty = 1'b0;
    din = 8'h77;
    output_full = 1'b0;
`ifdef RGB_PIXEL_UNPACK_ROW_PAD_EN
    p_empty = 1'b1;
    p_din = 8'h00;
    p_full = 1'b0;
`endif
    #3 rst = 1'b0;
    #9;
    check("reset_read_fifo", {31'd0, rd_b}, 32'd0);
    check("reset_write_fifo", {31'd0, wr_b}, 32'd0);
    check("reset_colours", {8'd0, red_b, green_b, blue_b}, 32'd0);
    repeat (2) @(posedge clk);

    // Basic unpack; the first pop happens on the edge right after release.
    chk_lat = 1;
    push_pixel(8'h10, 8'h20, 8'h30);
    release_rst = 1;
    tick();
    check("first_pop_after_release", pops, 32'd1);
    drain(50);

    // Back-to-back pixels: one pixel every four cycles.
    chk_tput = 1;
    last_wr_cyc = -1;
    push_pixel(8'h01, 8'h02, 8'h03);
    push_pixel(8'hFF, 8'h00, 8'h80);
    push_pixel(8'h7F, 8'hC3, 8'h3C);
    push_pixel(8'h55, 8'hAA, 8'h11);
    drain(60);
    chk_tput = 0;

    // Back-pressure: five stalled write cycles, then a single write.
    chk_lat = 0;
    stall_cnt = 0;
    full_hold = 5;
    chk_bp = 1;
    push_pixel(8'h91, 8'h92, 8'h93);
    push_pixel(8'hA1, 8'hA2, 8'hA3);
    drain(60);
    check("stall_cycles", stall_cnt, 32'd5);
    check("bp_write_seen", {31'd0, chk_bp}, 32'd0);

    // Input gaps plus padded-row stream on the padding instance.
    pops_before = pops;
    push_byte(8'hAA, 0);
    push_byte(8'hBB, 3);
    push_byte(8'hCC, 2);
    exp_q.push_back({8'hAA, 8'hBB, 8'hCC});
`ifdef RGB_PIXEL_UNPACK_ROW_PAD_EN
    for (int i = 1; i <= 6; i++) p_src.push_back(8'(i));
    p_src.push_back(8'hEE);
    p_src.push_back(8'hEE);
    p_src.push_back(8'h07);
    p_src.push_back(8'h08);
    p_src.push_back(8'h09);
    p_exp.push_back(24'h010203);
    p_exp.push_back(24'h040506);
    p_exp.push_back(24'h070809);
`endif
    drain(80);
    check("gap_pop_count", pops - pops_before, 32'd3);
`ifdef RGB_PIXEL_UNPACK_ROW_PAD_EN
    check("pad_pixels_outstanding", p_exp.size(), 32'd0);
`endif

    // Reset after two bytes of a pixel: the partial pixel is discarded.
    push_byte(8'h51, 0);
    push_byte(8'h52, 0);
    drain(20);
    @(negedge clk);
    input_empty = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("midreset_read_fifo", {31'd0, rd_b}, 32'd0);
    check("midreset_colours", {8'd0, red_b, green_b, blue_b}, 32'd0);
    byte_phase = 0;
    @(posedge clk);
    release_rst = 1;
    chk_lat = 1;
    push_pixel(8'h61, 8'h62, 8'h63);
    drain(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
